uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares one 32-bit UART transmitter among N_REQ word producers, such as capture channels, status and header words.
- Grants one requester at a time and latches its word.
- Sequences the transmitter's load and start controls, waits for the 4-byte frame to finish, then acknowledges the requester.
- Sits between the capture/packet logic and the transmitter; the transmitter's _rst is the same net as this block's.

Parameters:
N_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, cycles to wait for tx_busy to rise after start before flagging an error (>=2)
GAP_CYCLES, 0, idle cycles inserted after each completed word (0 = none)

Ports:
i_clk  in  1  system clock
_rst  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level; held until its ack
req_data  in  32*N_REQ  requester k's word in bits [32k+31:32k]
ack  out  N_REQ  one-cycle done pulse to the granted requester
err  out  1  one-cycle pulse alongside ack when the start timed out
tx_data  out  32  word to the transmitter's parallel load
tx_fetch  out  1  one-cycle load strobe to the transmitter
tx_transmit  out  1  one-cycle start strobe to the transmitter
tx_busy  in  1  transmitter busy flag
grant_id  out  clog2(N_REQ), min 1  index of the current or last granted requester
active  out  1  high from LOAD through DONE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, data register 0, rr pointer = N_REQ-1, so requester 0 has first priority. Reset mid-frame aborts silently with no ack and no err; the transmitter is reset by the same net.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, DONE, GAP.
- IDLE:
  - Sample req only in IDLE.
  - Winner = first asserted bit searching from (rr+1) mod N_REQ upward, with wrap.
  - On a winner: latch its word into tx_data, set grant_id and rr = winner, go to LOAD.
  - No request: stay.
- LOAD: tx_fetch=1 for exactly this cycle; -> START.
- START: tx_transmit=1 for exactly this cycle; clear the timeout counter; -> WAIT_BUSY.
  - tx_fetch and tx_transmit are never high in the same cycle.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment the counter. When counter==START_TIMEOUT-1, set the err flag and go to DONE.
- WAIT_DONE: wait for tx_busy=0 -> DONE. No timeout; a 32-bit frame is 40 bit times.
- DONE:
  - ack[grant_id]=1 for one cycle; err=1 the same cycle if flagged; clear the flag.
  - GAP_CYCLES>0 -> GAP, else -> IDLE.
- GAP: count GAP_CYCLES cycles, then -> IDLE.
- Latency:
  - req seen in IDLE at cycle 0: fetch at cycle 1, transmit at cycle 2.
  - ack occurs 1 cycle after tx_busy is seen low in WAIT_DONE.
  - Earliest next grant is the cycle after DONE, or after GAP.
- tx_data is stable from LOAD until the next grant; it is not cleared on DONE.
- A requester dropping req mid-transfer is ignored: the transfer completes and ack is still pulsed.
- Simultaneous requests: round-robin guarantees each asserted requester is served within N_REQ grants.
- A requester that holds req after its ack is re-arbitrated fairly; it wins again only if no other request is pending.
- tx_busy high while in IDLE is ignored; the block does not start LOAD early because of it.

Test Plan:
- Single request: req=0001, data0=0xDEADBEEF -> tx_fetch at cycle 1, tx_transmit at cycle 2, tx_data=0xDEADBEEF. With a transmitter model holding busy for 40 bit times -> ack=0001 for one cycle, err=0, grant_id=0.
- Contention: req=1111 held continuously, data k = 0x1111_1111*k, N_REQ=4 -> grant order 0,1,2,3,0. Exactly one ack bit per transfer; tx_fetch and tx_transmit never overlap.
- Round-robin resume: after serving 2, assert req=0101 -> grant 0, then 2; next with req=0100 only -> grant 2.
- Start timeout: tx_busy tied 0 -> ack and err pulse together 16 cycles after START; next request is still served.
- Gap: GAP_CYCLES=5, two pending requests -> exactly 5 idle cycles between DONE and the second LOAD; active low during the gap.
- Reset mid-frame: assert _rst low during WAIT_DONE, asynchronously and between clock edges -> outputs 0 immediately, no ack. After release with req=0010 -> grant_id=1, and requester 0 still has priority over 1 if both request.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 32-bit UART transmitter among N_REQ word producers.
// Grants one requester, loads/starts the transmitter, waits out the frame, then acks.
module uart_tx_scheduler #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 0,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 i_clk,
    input  logic                 _rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 err,
    output logic [31:0]          tx_data,
    output logic                 tx_fetch,
    output logic                 tx_transmit,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic [2:0]           dbg_state
);

    localparam int CW = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam int PW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5,
        GAP       = 3'd6
    } state_t;

    state_t            r_state;
    logic [31:0]       r_tx_data;
    logic [GW-1:0]     r_grant_id;
    logic [GW-1:0]     r_rr;
    logic [N_REQ-1:0]  r_ack;
    logic              r_err;
    logic              r_tx_fetch;
    logic              r_tx_transmit;
    logic              r_active;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_gap_cnt;

    logic              w_found;
    logic [GW-1:0]     w_winner;
    logic [N_REQ-1:0]  w_ack_set;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_found && req[(int'(r_rr) + i) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = GW'((int'(r_rr) + i) % N_REQ);
            end
        end
    end

    assign w_ack_set = N_REQ'(1) << r_grant_id;

    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            r_state       <= IDLE;
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_rr          <= GW'(N_REQ - 1);
            r_ack         <= '0;
            r_err         <= 1'b0;
            r_tx_fetch    <= 1'b0;
            r_tx_transmit <= 1'b0;
            r_active      <= 1'b0;
            r_cnt         <= '0;
            r_gap_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_tx_data  <= req_data[32*int'(w_winner) +: 32];
                        r_grant_id <= w_winner;
                        r_rr       <= w_winner;
                        r_tx_fetch <= 1'b1;
                        r_active   <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_fetch    <= 1'b0;
                    r_tx_transmit <= 1'b1;
                    r_state       <= START;
                end
                START: begin
                    r_tx_transmit <= 1'b0;
                    r_cnt         <= '0;
                    r_state       <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // The DONE cycle lands START_TIMEOUT cycles after START.
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (int'(r_cnt) == START_TIMEOUT - 2) begin
                        r_err   <= 1'b1;
                        r_ack   <= w_ack_set;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_ack   <= w_ack_set;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ack     <= '0;
                    r_err     <= 1'b0;
                    r_active  <= 1'b0;
                    r_gap_cnt <= '0;
                    r_state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (int'(r_gap_cnt) == GAP_CYCLES - 1) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack         = r_ack;
    assign err         = r_err;
    assign tx_data     = r_tx_data;
    assign tx_fetch    = r_tx_fetch;
    assign tx_transmit = r_tx_transmit;
    assign grant_id    = r_grant_id;
    assign active      = r_active;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a GAP_CYCLES=0 instance for the main function
// and a GAP_CYCLES=5 instance for the inter-word gap, each with a 40-cycle transmitter model.
module tb_uart_tx_scheduler;

    logic         clk;
    logic         rst_n;

    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   ack;
    logic         err;
    logic [31:0]  tx_data;
    logic         tx_fetch;
    logic         tx_transmit;
    logic         tx_busy;
    logic [1:0]   grant_id;
    logic         active;
    logic [2:0]   dbg_state;

    logic [3:0]   g_req;
    logic [127:0] g_req_data;
    logic [3:0]   g_ack;
    logic         g_err;
    logic [31:0]  g_tx_data;
    logic         g_tx_fetch;
    logic         g_tx_transmit;
    logic         g_tx_busy;
    logic [1:0]   g_grant_id;
    logic         g_active;
    logic [2:0]   g_dbg_state;

    logic         model_en;
    logic         busy_force;
    logic         m_busy;
    int           m_cnt;
    logic         gm_busy;
    int           gm_cnt;

    int           n_pass;
    int           n_total;

    uart_tx_scheduler #(.N_REQ(4), .START_TIMEOUT(16), .GAP_CYCLES(0)) dut (
        .i_clk       (clk),
        ._rst        (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .err         (err),
        .tx_data     (tx_data),
        .tx_fetch    (tx_fetch),
        .tx_transmit (tx_transmit),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .dbg_state   (dbg_state)
    );

    uart_tx_scheduler #(.N_REQ(4), .START_TIMEOUT(16), .GAP_CYCLES(5)) dut_gap (
        .i_clk       (clk),
        ._rst        (rst_n),
        .req         (g_req),
        .req_data    (g_req_data),
        .ack         (g_ack),
        .err         (g_err),
        .tx_data     (g_tx_data),
        .tx_fetch    (g_tx_fetch),
        .tx_transmit (g_tx_transmit),
        .tx_busy     (g_tx_busy),
        .grant_id    (g_grant_id),
        .active      (g_active),
        .dbg_state   (g_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // transmitter models: busy rises the cycle after the start strobe and lasts 40 cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (tx_transmit && model_en) begin
            m_busy <= 1'b1;
            m_cnt  <= 40;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_busy <= 1'b0;
        end
    end
    assign tx_busy = m_busy | busy_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gm_busy <= 1'b0;
            gm_cnt  <= 0;
        end else if (g_tx_transmit) begin
            gm_busy <= 1'b1;
            gm_cnt  <= 40;
        end else if (gm_cnt != 0) begin
            gm_cnt <= gm_cnt - 1;
            if (gm_cnt == 1) gm_busy <= 1'b0;
        end
    end
    assign g_tx_busy = gm_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (tx_fetch || tx_transmit) check("strobe_overlap", 64'(tx_fetch & tx_transmit), 64'd0);
    end

    // driver: one complete transfer, timed from the negedge at which the request is visible
    task automatic xfer(input int exp_id, input logic [31:0] exp_data, input bit exp_err,
                        input bit clr, input int exp_tack);
        int t;
        bit seen;
        t = 0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            t++;
            if (tx_fetch) seen = 1'b1;
        end
        check("fetch_seen", 64'(seen), 64'd1);
        check("fetch_latency", 64'(t), 64'd1);
        check("grant_id", 64'(grant_id), 64'(exp_id));
        check("tx_data_load", 64'(tx_data), 64'(exp_data));
        check("active_load", 64'(active), 64'd1);
        @(negedge clk);
        t++;
        check("transmit_strobe", 64'({tx_fetch, tx_transmit}), 64'b01);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            t++;
            if (ack != 4'd0) seen = 1'b1;
        end
        check("ack_seen", 64'(seen), 64'd1);
        check("ack_latency", 64'(t), 64'(exp_tack));
        check("ack_onehot", 64'(ack), 64'd1 << exp_id);
        check("err", 64'(err), 64'(exp_err));
        check("active_done", 64'(active), 64'd1);
        if (clr) req[exp_id] = 1'b0;
        @(negedge clk);
        check("ack_err_clear", 64'({ack, err}), 64'd0);
        check("tx_data_hold", 64'(tx_data), 64'(exp_data));
        check("active_idle", 64'(active), 64'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        int gap_cnt;
        bit seen;
        bit bad;
        n_pass     = 0;
        n_total    = 0;
        rst_n      = 1'b0;
        req        = 4'd0;
        req_data   = '0;
        g_req      = 4'd0;
        g_req_data = '0;
        model_en   = 1'b1;
        busy_force = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_outputs", 64'({ack, err, tx_fetch, tx_transmit, grant_id, active}), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst_n = 1'b1;

        // tx_busy high in IDLE with no request must not start a transfer
        busy_force = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (tx_fetch || dbg_state != 3'd0) bad = 1'b1;
        end
        busy_force = 1'b0;
        check("busy_in_idle_ignored", 64'(bad), 64'd0);

        // contention from reset: all four held, expect 0,1,2,3,0
        for (int k = 0; k < 4; k++) req_data[32*k +: 32] = 32'h1111_1111 * k;
        req = 4'b1111;
        xfer(0, 32'h0000_0000, 1'b0, 1'b0, 44);
        xfer(1, 32'h1111_1111, 1'b0, 1'b0, 44);
        xfer(2, 32'h2222_2222, 1'b0, 1'b0, 44);
        xfer(3, 32'h3333_3333, 1'b0, 1'b0, 44);
        xfer(0, 32'h0000_0000, 1'b0, 1'b0, 44);
        req = 4'd0;

        // single request with full latency check
        @(negedge clk);
        req_data[31:0] = 32'hDEAD_BEEF;
        req = 4'b0001;
        xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b1, 44);

        // round-robin resume
        req = 4'b0100;
        xfer(2, 32'h2222_2222, 1'b0, 1'b1, 44);
        req = 4'b0101;
        xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b1, 44);
        xfer(2, 32'h2222_2222, 1'b0, 1'b1, 44);
        req = 4'b0100;
        xfer(2, 32'h2222_2222, 1'b0, 1'b1, 44);

        // start timeout, then a normal transfer still works
        model_en = 1'b0;
        req = 4'b0001;
        xfer(0, 32'hDEAD_BEEF, 1'b1, 1'b1, 18);
        model_en = 1'b1;
        req = 4'b1000;
        xfer(3, 32'h3333_3333, 1'b0, 1'b1, 44);

        // asynchronous reset in the middle of a frame
        req_data[31:0] = 32'hCAFE_F00D;
        req = 4'b0001;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (tx_fetch) seen = 1'b1;
        end
        check("midrst_fetch_seen", 64'(seen), 64'd1);
        for (int k = 0; k < 10; k++) @(negedge clk);
        check("midrst_in_wait_done", 64'(dbg_state), 64'd4);
        check("midrst_tx_data_before", 64'(tx_data), 64'hCAFE_F00D);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({ack, err, tx_fetch, tx_transmit, grant_id, active}), 64'd0);
        check("midrst_tx_data", 64'(tx_data), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack != 4'd0 || err) bad = 1'b1;
        end
        check("midrst_no_ack", 64'(bad), 64'd0);
        req = 4'b0010;
        rst_n = 1'b1;
        xfer(1, 32'h1111_1111, 1'b0, 1'b1, 44);

        // after a reset requester 0 again outranks requester 1
        pulse_reset();
        req = 4'b0011;
        xfer(0, 32'hCAFE_F00D, 1'b0, 1'b1, 44);
        xfer(1, 32'h1111_1111, 1'b0, 1'b1, 44);

        // gap instance: two pending requests, five GAP cycles between DONE and the next LOAD
        g_req_data[31:0]  = 32'hA5A5_A5A5;
        g_req_data[63:32] = 32'h5A5A_5A5A;
        g_req = 4'b0011;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (g_ack != 4'd0) seen = 1'b1;
        end
        check("gap_first_ack_seen", 64'(seen), 64'd1);
        check("gap_first_ack", 64'(g_ack), 64'b0001);
        check("gap_first_data", 64'(g_tx_data), 64'hA5A5_A5A5);
        g_req[0] = 1'b0;
        t = 0;
        gap_cnt = 0;
        bad = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            t++;
            if (g_tx_fetch) seen = 1'b1;
            else begin
                if (g_active) bad = 1'b1;
                if (g_dbg_state == 3'd6) gap_cnt++;
            end
        end
        check("gap_second_fetch_seen", 64'(seen), 64'd1);
        check("gap_cycles", 64'(gap_cnt), 64'd5);
        check("gap_done_to_load", 64'(t), 64'd7);
        check("gap_active_low", 64'(bad), 64'd0);
        check("gap_second_grant", 64'(g_grant_id), 64'd1);
        check("gap_second_data", 64'(g_tx_data), 64'h5A5A_5A5A);
        g_req = 4'd0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
